// File: rtl/seg7_scroll_mux_if.sv
// Host-side write port of the scrolling 7-segment driver: append, clear and
// back-pressure.
interface seg7_scroll_mux_if;
   // Handshake: a character is taken on a rising clk_2 edge when wr_en && wr_ready
   // && !clear. wr_ready is high while the buffer has room. When wr_ready is low the
   // write is dropped, not held. clear empties the buffer and beats a same-cycle write.
   logic       clear;
   logic       wr_en;
   logic [5:0] wr_code;
   logic       wr_ready;

   modport master (output clear, output wr_en, output wr_code, input wr_ready);
   modport slave  (input clear, input wr_en, input wr_code, output wr_ready);
endinterface

// File: rtl/seg7_scroll_mux.sv
// Time-multiplexed NDIGITS x 7-segment driver with an append-only message buffer,
// showing the message either static (left-aligned) or scrolling with an end marker.
module seg7_scroll_mux #(
   parameter int NDIGITS    = 4,
   parameter int DEPTH      = 16,
   parameter int SCAN_DIV   = 4,
   parameter int SCROLL_DIV = 8
) (
   input  logic                       clk_2,
   input  logic                       rst_n,
   seg7_scroll_mux_if.slave           host,
   input  logic                       mode,
   output logic [7:0]                 SEG,
   output logic [NDIGITS-1:0]         dig_sel,
   output logic [$clog2(DEPTH):0]     msg_len,
   output logic [$clog2(DEPTH)-1:0]   scroll_pos,
   output logic [1:0]                 state_dbg
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = LW + 1;
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

   localparam logic [1:0] S_EMPTY  = 2'd0;
   localparam logic [1:0] S_STATIC = 2'd1;
   localparam logic [1:0] S_SCROLL = 2'd2;

   logic [1:0]    state, state_nxt;
   logic [LW-1:0] len;
   logic [AW-1:0] pos;
   logic [SW-1:0] scan_cnt;
   logic [IW-1:0] idx;
   logic [FW-1:0] frame_cnt;
   logic [5:0]    msg_buf [DEPTH];

   logic          not_full, wr_fire, scan_wrap, frame_end, step;
   logic [PW-1:0] sum_idx;
   logic [AW-1:0] scroll_addr;
   logic          end_mark;
   logic [7:0]    seg_nxt;

   function automatic logic [6:0] decode(input logic [5:0] code);
      case (code)
         6'd0:  decode = 7'h3F;  6'd1:  decode = 7'h06;  6'd2:  decode = 7'h5B;
         6'd3:  decode = 7'h4F;  6'd4:  decode = 7'h66;  6'd5:  decode = 7'h6D;
         6'd6:  decode = 7'h7D;  6'd7:  decode = 7'h07;  6'd8:  decode = 7'h7F;
         6'd9:  decode = 7'h6F;  6'd10: decode = 7'h77;  6'd11: decode = 7'h7C;
         6'd12: decode = 7'h39;  6'd13: decode = 7'h5E;  6'd14: decode = 7'h79;
         6'd15: decode = 7'h71;  6'd16: decode = 7'h77;  6'd17: decode = 7'h7C;
         6'd18: decode = 7'h39;  6'd19: decode = 7'h58;  6'd20: decode = 7'h5E;
         6'd21: decode = 7'h79;  6'd22: decode = 7'h71;  6'd23: decode = 7'h6F;
         6'd24: decode = 7'h76;  6'd25: decode = 7'h74;  6'd26: decode = 7'h06;
         6'd27: decode = 7'h04;  6'd28: decode = 7'h1E;  6'd29: decode = 7'h38;
         6'd30: decode = 7'h54;  6'd31: decode = 7'h3F;  6'd32: decode = 7'h5C;
         6'd33: decode = 7'h73;  6'd34: decode = 7'h67;  6'd35: decode = 7'h50;
         6'd36: decode = 7'h6D;  6'd37: decode = 7'h78;  6'd38: decode = 7'h3E;
         6'd39: decode = 7'h1C;  6'd40: decode = 7'h6E;  6'd41: decode = 7'h63;
         default: decode = 7'h40;
      endcase
   endfunction

   assign not_full      = (len < LW'(DEPTH));
   assign host.wr_ready = not_full;
   assign wr_fire       = host.wr_en && not_full && !host.clear;
   assign scan_wrap     = (scan_cnt == SW'(SCAN_DIV - 1));
   assign frame_end     = scan_wrap && (idx == IW'(NDIGITS - 1));
   assign step          = (state == S_SCROLL) && frame_end && (frame_cnt == FW'(SCROLL_DIV - 1));

   always_comb begin
      state_nxt = state;
      if (host.clear) begin
         state_nxt = S_EMPTY;
      end else if (state != S_EMPTY || len != '0) begin
         state_nxt = mode ? S_SCROLL : S_STATIC;
      end
   end

   // (pos + idx) mod len; pos < len and idx < NDIGITS, so NDIGITS subtractions always suffice.
   always_comb begin
      sum_idx = PW'(pos) + PW'(idx);
      for (int i = 0; i < NDIGITS; i++) begin
         if (len != '0 && sum_idx >= PW'(len)) sum_idx = sum_idx - PW'(len);
      end
      scroll_addr = sum_idx[AW-1:0];
      end_mark    = (sum_idx == PW'(len) - PW'(1));
   end

   always_comb begin
      seg_nxt = '0;
      case (state)
         S_STATIC: if (LW'(idx) < len) seg_nxt = {1'b0, decode(msg_buf[AW'(idx)])};
         S_SCROLL: if (len != '0)      seg_nxt = {end_mark, decode(msg_buf[scroll_addr])};
         default:  seg_nxt = '0;
      endcase
   end

   always_ff @(posedge clk_2) begin
      if (wr_fire) msg_buf[len[AW-1:0]] <= host.wr_code;
   end

   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_EMPTY;
         len       <= '0;
         pos       <= '0;
         scan_cnt  <= '0;
         idx       <= '0;
         frame_cnt <= '0;
         SEG       <= '0;
         dig_sel   <= '0;
      end else begin
         state    <= state_nxt;
         scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
         if (scan_wrap) idx <= (idx == IW'(NDIGITS - 1)) ? '0 : idx + IW'(1);

         if (host.clear)   len <= '0;
         else if (wr_fire) len <= len + LW'(1);

         // Frame counting and position only live in scroll; every entry starts from zero.
         if (state_nxt != S_SCROLL) begin
            frame_cnt <= '0;
            pos       <= '0;
         end else if (state == S_SCROLL && frame_end) begin
            frame_cnt <= step ? '0 : frame_cnt + FW'(1);
            if (step) pos <= (LW'(pos) == len - LW'(1)) ? '0 : pos + AW'(1);
         end

         dig_sel <= NDIGITS'(1) << idx;
         SEG     <= seg_nxt;
      end
   end

   assign msg_len    = len;
   assign scroll_pos = pos;
   assign state_dbg  = state;
endmodule

// File: tb/tb_seg7_scroll_mux.sv
// Self-checking bench for seg7_scroll_mux: directed scenarios plus randomized traffic,
// all compared every cycle against a message-level model of the display.
module tb_seg7_scroll_mux;
  localparam int NDIGITS    = 4;
  localparam int DEPTH      = 16;
  localparam int SCAN_DIV   = 4;
  localparam int SCROLL_DIV = 8;
  localparam int FRAME      = NDIGITS * SCAN_DIV;
  localparam int V_EMPTY = 0, V_STATIC = 1, V_SCROLL = 2;

  localparam logic [6:0] HEX_G [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [6:0] LET_G [26] = '{7'h77, 7'h7C, 7'h39, 7'h58, 7'h5E, 7'h79, 7'h71, 7'h6F,
                                         7'h76, 7'h74, 7'h06, 7'h04, 7'h1E, 7'h38, 7'h54, 7'h3F,
                                         7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C,
                                         7'h6E, 7'h63};
  localparam logic [7:0] STATIC_SEG [4] = '{8'h06, 8'h5B, 8'h4F, 8'h00};
  localparam int HELLO [5]     = '{24, 21, 29, 29, 31};
  localparam int HELLO_POS [6] = '{0, 1, 2, 3, 4, 0};

  // clock / reset
  logic clk_2 = 1'b0;
  logic rst_n = 1'b0;
  logic mode  = 1'b0;
  always #5 clk_2 = ~clk_2;

  logic [7:0]               seg;
  logic [NDIGITS-1:0]       dig_sel;
  logic [$clog2(DEPTH):0]   msg_len;
  logic [$clog2(DEPTH)-1:0] scroll_pos;
  logic [1:0]               state_dbg;

  seg7_scroll_mux_if host_if ();

  seg7_scroll_mux #(.NDIGITS(NDIGITS), .DEPTH(DEPTH), .SCAN_DIV(SCAN_DIV), .SCROLL_DIV(SCROLL_DIV)) dut (
    .clk_2      (clk_2),
    .rst_n      (rst_n),
    .host       (host_if),
    .mode       (mode),
    .SEG        (seg),
    .dig_sel    (dig_sel),
    .msg_len    (msg_len),
    .scroll_pos (scroll_pos),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int code);
    if (code < 16) return HEX_G[code];
    if (code < 42) return LET_G[code - 16];
    return 7'h40;
  endfunction

  // reference model: message as a queue, display computed from cycle count since reset
  logic [5:0]         msg [$];
  int                 view = V_EMPTY;
  int                 pos = 0;
  int                 frames = 0;
  int                 t = 0;
  logic [7:0]         exp_seg = '0;
  logic [NDIGITS-1:0] exp_dig = '0;

  initial forever begin
    int  m_idx, m_len, m_a;
    bit  fe;
    @(posedge clk_2 or negedge rst_n);
    if (!rst_n) begin
      msg.delete();
      view = V_EMPTY; pos = 0; frames = 0; t = 0;
      exp_seg = '0; exp_dig = '0;
    end else begin
      m_idx   = (t / SCAN_DIV) % NDIGITS;
      m_len   = msg.size();
      exp_dig = NDIGITS'(1) << m_idx;
      exp_seg = '0;
      if (view == V_STATIC && m_idx < m_len) begin
        exp_seg = {1'b0, glyph(int'(msg[m_idx]))};
      end else if (view == V_SCROLL && m_len > 0) begin
        m_a = (pos + m_idx) % m_len;
        exp_seg = {(m_a == m_len - 1), glyph(int'(msg[m_a]))};
      end
      fe = ((t % FRAME) == FRAME - 1);
      if (host_if.clear) begin
        msg.delete();
        view = V_EMPTY; pos = 0; frames = 0;
      end else begin
        if (host_if.wr_en && m_len < DEPTH) msg.push_back(host_if.wr_code);
        if (view == V_SCROLL && fe) begin
          frames++;
          if (frames == SCROLL_DIV) begin
            frames = 0;
            pos = (pos + 1) % m_len;
          end
        end
        if (view != V_EMPTY || m_len > 0) view = mode ? V_SCROLL : V_STATIC;
        if (view != V_SCROLL) begin
          pos = 0; frames = 0;
        end
      end
      t++;
    end
  end

  // scoreboard compare, once per cycle away from the active edge
  initial forever begin
    @(negedge clk_2);
    if (rst_n) begin
      check("seg", seg, exp_seg);
      check("dig_sel", dig_sel, exp_dig);
      check("msg_len", msg_len, msg.size());
      check("scroll_pos", scroll_pos, pos);
      check("wr_ready", host_if.wr_ready, msg.size() < DEPTH);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // driver tasks (called at a negedge, return at the next negedge)
  task automatic write_char(input int code);
    host_if.wr_en   = 1'b1;
    host_if.wr_code = 6'(code);
    @(negedge clk_2);
    host_if.wr_en   = 1'b0;
  endtask

  task automatic clear_pulse();
    host_if.clear = 1'b1;
    @(negedge clk_2);
    host_if.clear = 1'b0;
  endtask

  task automatic wait_digit(input int d);
    int n = 0;
    while (dig_sel !== (NDIGITS'(1) << d) && n < 100) begin
      @(negedge clk_2);
      n++;
    end
    check($sformatf("reach_digit%0d", d), dig_sel, NDIGITS'(1) << d);
  endtask

  initial begin
    int n, got, prev, last_change, dp_seen, wp;
    host_if.clear = 1'b0; host_if.wr_en = 1'b0; host_if.wr_code = '0;

    // reset held, then released
    repeat (3) @(negedge clk_2);
    check("rst_seg", seg, 8'h00);
    check("rst_dig", dig_sel, 0);
    check("rst_ready", host_if.wr_ready, 1);
    check("rst_len", msg_len, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    check("rel_seg", seg, 8'h00);
    check("rel_len", msg_len, 0);
    repeat (2) @(negedge clk_2);

    // static display of 1,2,3
    mode = 1'b0;
    write_char(1); write_char(2); write_char(3);
    repeat (2 * FRAME) @(negedge clk_2);
    wait_digit(0); check("static_d0", seg, STATIC_SEG[0]);
    wait_digit(1); check("static_d1", seg, STATIC_SEG[1]);
    n = 0;
    while (dig_sel === 4'b0010 && n < 20) begin
      @(negedge clk_2);
      n++;
    end
    check("digit_dwell", n, SCAN_DIV);
    wait_digit(2); check("static_d2", seg, STATIC_SEG[2]);
    wait_digit(3); check("static_d3", seg, STATIC_SEG[3]);

    // fill to DEPTH, then one more
    clear_pulse();
    for (int i = 0; i < DEPTH; i++) write_char($urandom_range(0, 63));
    check("full_ready", host_if.wr_ready, 0);
    check("full_len", msg_len, 16);
    write_char(7);
    check("full_drop_len", msg_len, 16);

    // HELLO scrolling
    mode = 1'b1;
    clear_pulse();
    for (int i = 0; i < 5; i++) write_char(HELLO[i]);
    check("hello_pos0", scroll_pos, 0);
    got = 1; prev = scroll_pos; n = 0; last_change = 0; dp_seen = 0;
    while (got < 6 && n < 2000) begin
      @(negedge clk_2);
      n++;
      if (seg[7]) begin
        dp_seen++;
        check("dp_on_O", seg[6:0], 7'h3F);
      end
      if (scroll_pos != prev) begin
        check($sformatf("hello_pos%0d", got), scroll_pos, HELLO_POS[got]);
        if (got == 2) check("step_period", n - last_change, SCROLL_DIV * FRAME);
        last_change = n;
        prev = scroll_pos;
        got++;
      end
    end
    check("hello_steps", got, 6);
    check("dp_seen", dp_seen > 0, 1);

    // asynchronous reset mid-scroll at pos=3
    n = 0;
    while (scroll_pos != 3 && n < 1000) begin
      @(negedge clk_2);
      n++;
    end
    check("reach_pos3", scroll_pos, 3);
    @(posedge clk_2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", seg, 8'h00);
    check("arst_dig", dig_sel, 0);
    check("arst_len", msg_len, 0);
    check("arst_pos", scroll_pos, 0);
    check("arst_ready", host_if.wr_ready, 1);
    @(negedge clk_2);
    rst_n = 1'b1;

    // clear beats a same-cycle write
    write_char(10); write_char(11); write_char(12);
    repeat (FRAME) @(negedge clk_2);
    host_if.clear = 1'b1; host_if.wr_en = 1'b1; host_if.wr_code = 6'd5;
    @(negedge clk_2);
    host_if.clear = 1'b0; host_if.wr_en = 1'b0;
    check("clr_len", msg_len, 0);
    check("clr_pos", scroll_pos, 0);
    @(negedge clk_2);
    check("clr_seg", seg, 8'h00);
    repeat (FRAME) @(negedge clk_2);
    check("clr_len_hold", msg_len, 0);

    // randomized traffic: slow growth first (appends while scrolling), then bursts
    for (int c = 0; c < 6000; c++) begin
      wp = (c < 3000) ? 40 : 4;
      host_if.clear   = ($urandom_range(0, 599) == 0);
      host_if.wr_en   = ($urandom_range(0, wp - 1) == 0);
      host_if.wr_code = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 399) == 0) mode = ~mode;
      @(negedge clk_2);
    end
    host_if.clear = 1'b0; host_if.wr_en = 1'b0;
    @(negedge clk_2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
